// File: rtl/timer_host.sv
// rtl/timer_host.sv - initiator-side controller for the MCU 16-bit timer peripheral
// Command FSM drives timer strobes; independent interrupt service handles flag clear, irq and overflow count.
module timer_host #(
    parameter int timerwid  = 16,
    parameter int CLR_PULSE = 2,
    parameter int OVF_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [timerwid-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [timerwid-1:0] rsp_data,
    output logic                irq,
    input  logic                irq_ack,
    output logic [OVF_W-1:0]    ovf_count,
    output logic                tmr_cs,
    output logic                tmr_wr,
    output logic                tmr_start,
    output logic                tmr_rd,
    output logic [timerwid-1:0] tmr_datain,
    input  logic [timerwid-1:0] tmr_dataout,
    input  logic                tmr_intrup,
    output logic                tmr_clearFlag
);
    localparam int CLR_W = $clog2(CLR_PULSE + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RD, RDW} state_t;

    state_t                state_q, state_d;
    logic                  running_q, running_d;
    logic                  cs_q, cs_d;
    logic [timerwid-1:0]   datain_q, datain_d;
    logic [timerwid-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  intr_q, intr_d;
    logic                  irq_q, irq_d;
    logic [OVF_W-1:0]      ovf_q, ovf_d;
    logic [CLR_W-1:0]      clr_q, clr_d;
    logic                  rise;

    assign rise = tmr_intrup & ~intr_q;

    always_comb begin
        state_d     = state_q;
        running_d   = running_q;
        cs_d        = 1'b1;
        datain_d    = datain_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        intr_d      = tmr_intrup;
        irq_d       = irq_q;
        ovf_d       = ovf_q;
        clr_d       = clr_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00: begin
                            datain_d = cmd_data;
                            state_d  = LOAD;
                        end
                        2'b01: running_d = 1'b1;
                        2'b10: running_d = 1'b0;
                        default: state_d = RD;
                    endcase
                end
            end
            LOAD: state_d = IDLE;
            RD:   state_d = RDW;
            default: begin
                // Timer registered its read data on the RD edge; capture it now.
                rsp_data_d  = tmr_dataout;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        if (irq_ack) begin
            irq_d = 1'b0;
            ovf_d = '0;
        end
        // A rise wins over a simultaneous ack so no overflow is lost.
        if (rise) begin
            irq_d = 1'b1;
            if (irq_ack)
                ovf_d = OVF_W'(1);
            else if (ovf_q != {OVF_W{1'b1}})
                ovf_d = ovf_q + OVF_W'(1);
            clr_d = CLR_W'(CLR_PULSE);
        end else if (clr_q != '0) begin
            clr_d = clr_q - CLR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            cs_q        <= 1'b0;
            datain_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            intr_q      <= 1'b0;
            irq_q       <= 1'b0;
            ovf_q       <= '0;
            clr_q       <= '0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            cs_q        <= cs_d;
            datain_q    <= datain_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            intr_q      <= intr_d;
            irq_q       <= irq_d;
            ovf_q       <= ovf_d;
            clr_q       <= clr_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign tmr_wr        = (state_q == LOAD);
    assign tmr_rd        = (state_q == RD);
    assign tmr_start     = running_q & (state_q != LOAD);
    assign tmr_cs        = cs_q;
    assign tmr_datain    = datain_q;
    assign tmr_clearFlag = (clr_q != '0);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign irq           = irq_q;
    assign ovf_count     = ovf_q;
endmodule

// File: tb/tb_timer_host.sv
// tb/tb_timer_host.sv - scoreboard bench for timer_host
// Directed commands; a negedge monitor checks each rsp_valid against queued data and due cycle.
module tb_timer_host;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_START = 2'b01, OP_STOP = 2'b10, OP_READ = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        irq;
    logic        irq_ack = 1'b0;
    logic [7:0]  ovf_count;
    logic        tmr_cs, tmr_wr, tmr_start, tmr_rd, tmr_clearFlag;
    logic [15:0] tmr_datain;
    logic [15:0] tmr_dataout = 16'h0;
    logic        tmr_intrup = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    timer_host #(.timerwid(16), .CLR_PULSE(2), .OVF_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .irq(irq), .irq_ack(irq_ack), .ovf_count(ovf_count),
        .tmr_cs(tmr_cs), .tmr_wr(tmr_wr), .tmr_start(tmr_start), .tmr_rd(tmr_rd),
        .tmr_datain(tmr_datain), .tmr_dataout(tmr_dataout),
        .tmr_intrup(tmr_intrup), .tmr_clearFlag(tmr_clearFlag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accept edge with cmd_valid dropped.
    task automatic issue(input logic [1:0] op, input logic [15:0] d, input bit expect_rsp);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL issue_timeout: got cmd_ready 0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = (op == OP_LOAD) ? d : 16'h0;
        if (op == OP_READ) begin
            tmr_dataout = d;
            if (expect_rsp) sb.push_back('{data: d, due: cyc + 3});
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid 1 data 0x%0h expected none", rsp_data);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        repeat (3) tick();
        // Reset state, sampled while still in reset
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cs", tmr_cs, 0);
        check("rst_strobes", {tmr_wr, tmr_start, tmr_rd, tmr_clearFlag}, 4'b0000);
        check("rst_irq_ovf", {irq, ovf_count}, 9'h0);
        check("rst_rsp", {rsp_valid, rsp_data}, 17'h0);
        check("rst_datain", tmr_datain, 16'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("cs_high", tmr_cs, 1);

        // 1. LOAD 0xFFF0, START, overflow
        issue(OP_LOAD, 16'hFFF0, 1'b0);
        check("load_wr", tmr_wr, 1);
        check("load_start0", tmr_start, 0);
        check("load_datain", tmr_datain, 16'hFFF0);
        check("load_ready", cmd_ready, 0);
        tick();
        check("load_wr_end", {tmr_wr, cmd_ready}, 2'b01);
        issue(OP_START, 16'h0, 1'b0);
        check("start_run", tmr_start, 1);
        issue(OP_START, 16'h0, 1'b0);
        check("start_again", {tmr_start, cmd_ready}, 2'b11);
        repeat (17) tick();
        tmr_intrup = 1'b1;
        tick();
        check("ovf_irq", irq, 1);
        check("ovf_cnt", ovf_count, 1);
        check("ovf_clr1", tmr_clearFlag, 1);
        tick();
        check("ovf_clr2", tmr_clearFlag, 1);
        tmr_intrup = 1'b0;
        tick();
        check("ovf_clr_end", tmr_clearFlag, 0);
        check("ovf_irq_held", irq, 1);

        // 2. READ while running
        issue(OP_READ, 16'h5A5A, 1'b1);
        check("rd_strobe", {tmr_rd, cmd_ready}, 2'b10);
        tick();
        check("rd_wait", {tmr_rd, cmd_ready}, 2'b00);
        tick();
        check("rd_done", {tmr_rd, cmd_ready, tmr_start}, 3'b011);
        tick();
        check("rsp_hold", rsp_data, 16'h5A5A);

        // 3. LOAD while running, then READ
        issue(OP_LOAD, 16'h1234, 1'b0);
        check("reload_start0", {tmr_start, tmr_wr}, 2'b01);
        tick();
        check("reload_resume", {tmr_start, tmr_wr}, 2'b10);
        issue(OP_READ, 16'h1240, 1'b1);
        repeat (3) tick();
        issue(OP_STOP, 16'h0, 1'b0);
        check("stop", tmr_start, 0);

        // 4. Overflow saturation without ack
        for (int i = 0; i < 260; i++) begin
            tmr_intrup = 1'b1;
            tick();
            tmr_intrup = 1'b0;
            tick();
        end
        check("sat_cnt", ovf_count, 8'hFF);
        check("sat_irq", irq, 1);

        // Rise during active clear sequence restarts it
        repeat (3) tick();
        tmr_intrup = 1'b1;
        tick();
        tmr_intrup = 1'b0;
        tick();
        tmr_intrup = 1'b1;
        tick();
        check("clr_restart1", tmr_clearFlag, 1);
        tmr_intrup = 1'b0;
        tick();
        check("clr_restart2", tmr_clearFlag, 1);
        tick();
        check("clr_restart_end", tmr_clearFlag, 0);

        // 5. Ack coincident with rise, then ack alone
        tmr_intrup = 1'b1;
        irq_ack    = 1'b1;
        tick();
        check("ack_rise_irq", irq, 1);
        check("ack_rise_cnt", ovf_count, 1);
        irq_ack    = 1'b0;
        tmr_intrup = 1'b0;
        repeat (3) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_irq", irq, 0);
        check("ack_cnt", ovf_count, 0);

        // 6. Reset during RD: dropped, no response
        issue(OP_READ, 16'hDEAD, 1'b0);
        check("rrd_strobe", tmr_rd, 1);
        rst_n = 1'b0;
        tick();
        check("rrd_rst", {tmr_rd, cmd_ready, rsp_valid, tmr_cs}, 4'b0100);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rrd_after", {cmd_ready, rsp_valid, tmr_start}, 3'b100);

        // Reset during clearFlag with flag still high
        tmr_intrup = 1'b1;
        tick();
        check("rclr_pre", {irq, tmr_clearFlag}, 2'b11);
        rst_n = 1'b0;
        tick();
        check("rclr_rst", {irq, tmr_clearFlag, ovf_count}, 10'h0);
        rst_n = 1'b1;
        tick();
        check("rclr_irq", irq, 1);
        check("rclr_cnt", ovf_count, 1);
        check("rclr_clr1", tmr_clearFlag, 1);
        tick();
        check("rclr_clr2", tmr_clearFlag, 1);
        tmr_intrup = 1'b0;
        tick();
        check("rclr_clr_end", tmr_clearFlag, 0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
